// File: rtl/dcache_miss_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache for the M stage.
// Read hits return in the same cycle; read misses and all stores stall the pipeline until the memory ack arrives.
module dcache_miss_ctrl #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDRESS_WIDTH  = 32,
    parameter int INDEX_WIDTH    = 3,
    parameter int MEM_ADDR_WIDTH = 17
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      MemReadM,
    input  logic                      MemWriteM,
    input  logic [ADDRESS_WIDTH-1:0]  A,
    input  logic [DATA_WIDTH-1:0]     WD,
    input  logic                      WE0,
    input  logic                      WE1,
    input  logic                      WE2,
    input  logic                      WE3,
    output logic [DATA_WIDTH-1:0]     RD,
    output logic                      StallM,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    output logic [3:0]                mem_be,
    input  logic [DATA_WIDTH-1:0]     mem_rdata,
    input  logic                      mem_ack,
    output logic [31:0]               hit_cnt,
    output logic [31:0]               miss_cnt
);

    localparam int NUM_LINES = 1 << INDEX_WIDTH;
    localparam int TAG_WIDTH = ADDRESS_WIDTH - 2 - INDEX_WIDTH;

    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, RESP} stateT;

    stateT state, nextState;

    logic [NUM_LINES-1:0]  validArr;
    logic [TAG_WIDTH-1:0]  tagArr  [NUM_LINES];
    logic [DATA_WIDTH-1:0] dataArr [NUM_LINES];
    logic [DATA_WIDTH-1:0] respQ;

    logic [INDEX_WIDTH-1:0] index;
    logic [TAG_WIDTH-1:0]   tag;
    logic [3:0]             byteEn;
    logic                   hit;
    logic                   loadOnly;
    logic                   unusedAddrBits;

    assign index          = A[2+INDEX_WIDTH-1:2];
    assign tag            = A[ADDRESS_WIDTH-1:2+INDEX_WIDTH];
    assign byteEn         = {WE3, WE2, WE1, WE0};
    assign hit            = validArr[index] && (tagArr[index] == tag);
    assign loadOnly       = MemReadM && !MemWriteM;
    assign unusedAddrBits = ^A[1:0];

    // The request is a pure function of the state register, so it rises on the edge into a wait state.
    assign mem_req   = (state == RD_WAIT) || (state == WR_WAIT);
    assign mem_addr  = {A[MEM_ADDR_WIDTH-1:2], 2'b00};
    assign mem_wdata = WD;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            validArr <= '0;
            respQ    <= '0;
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (state == IDLE && loadOnly) begin
                if (hit) begin
                    hit_cnt <= hit_cnt + 32'd1;
                end else begin
                    miss_cnt <= miss_cnt + 32'd1;
                end
            end
            if (state == RD_WAIT && mem_ack) begin
                validArr[index] <= 1'b1;
                respQ           <= mem_rdata;
            end
            // A store reports zero in its response cycle.
            if (state == WR_WAIT && mem_ack) begin
                respQ <= '0;
            end
        end
    end

    // NOTE: tag/data storage has no reset; the valid bits alone decide whether a line is usable.
    always_ff @(posedge CLK) begin
        if (!RST && state == RD_WAIT && mem_ack) begin
            tagArr[index]  <= tag;
            dataArr[index] <= mem_rdata;
        end else if (!RST && state == WR_WAIT && mem_ack && hit) begin
            for (int b = 0; b < 4; b++) begin
                if (byteEn[b]) begin
                    dataArr[index][8*b +: 8] <= WD[8*b +: 8];
                end
            end
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        nextState = state;
        StallM    = 1'b0;
        RD        = '0;
        mem_we    = 1'b0;
        mem_be    = 4'b0000;
        unique case (state)
            IDLE: begin
                if (MemWriteM) begin
                    StallM    = 1'b1;
                    nextState = WR_WAIT;
                end else if (MemReadM && !hit) begin
                    StallM    = 1'b1;
                    nextState = RD_WAIT;
                end else if (MemReadM) begin
                    RD = dataArr[index];
                end
            end
            RD_WAIT: begin
                StallM = 1'b1;
                mem_be = 4'b1111;
                if (mem_ack) begin
                    nextState = RESP;
                end
            end
            WR_WAIT: begin
                StallM = 1'b1;
                mem_we = 1'b1;
                mem_be = byteEn;
                if (mem_ack) begin
                    nextState = RESP;
                end
            end
            RESP: begin
                RD        = respQ;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

endmodule
